serial_slice_adder: RTL and testbench

// - Multi-cycle, parametrised successor to the single-bit combinational adder cells.
// - Adds two WIDTH-bit operands SLICE bits per clock; a registered carry links consecutive slices.
// - Trades latency for area in the datapath.
// - Valid/ready handshakes on input and output, so it drops into pipelined datapaths with back-pressure.

---
 rtl/serial_slice_adder.sv | 134 +++++++++++++
 tb/tb_serial_slice_adder.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_slice_adder.sv
// Slice-serial adder: adds two WIDTH-bit operands SLICE bits per clock with valid/ready handshakes.
// Optional feature macro SUBTRACT_EN adds the op_sub port (A + ~B + 1 when op_sub=1).
module serial_slice_adder #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SUBTRACT_EN
  input  logic             op_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST_SLICE = CW'(NSLICE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_c_out;
  logic             r_ovf;
  logic             r_out_valid;
  logic             r_in_ready;

  logic             w_sub;
  logic [WIDTH-1:0] w_b_cap;
  logic             w_cin_cap;
  logic [SLICE:0]   w_slice;
  logic             w_msb_cin;
  logic [WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0] w_a_next;
  logic [WIDTH-1:0] w_b_next;

`ifdef SUBTRACT_EN
  assign w_sub = op_sub;
`else
  assign w_sub = 1'b0;
`endif

  // Subtraction is folded in at capture time: B is stored inverted and the carry seeded with 1.
  assign w_b_cap   = w_sub ? ~b : b;
  assign w_cin_cap = w_sub ? 1'b1 : c_in;

  assign w_slice    = {1'b0, r_a[SLICE-1:0]} + {1'b0, r_b[SLICE-1:0]} + {{SLICE{1'b0}}, r_carry};
  // Carry into the top bit of this slice, recovered from that bit's sum = a ^ b ^ cin.
  assign w_msb_cin  = r_a[SLICE-1] ^ r_b[SLICE-1] ^ w_slice[SLICE-1];
  assign w_acc_next = (r_acc >> SLICE) | (WIDTH'(w_slice[SLICE-1:0]) << (WIDTH - SLICE));
  assign w_a_next   = r_a >> SLICE;
  assign w_b_next   = r_b >> SLICE;

  // Control FSM and datapath; r_acc is the working shift register so sum only changes on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= {WIDTH{1'b0}};
      r_b         <= {WIDTH{1'b0}};
      r_acc       <= {WIDTH{1'b0}};
      r_carry     <= 1'b0;
      r_cnt       <= {CW{1'b0}};
      r_sum       <= {WIDTH{1'b0}};
      r_c_out     <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_a        <= a;
            r_b        <= w_b_cap;
            r_carry    <= w_cin_cap;
            r_cnt      <= {CW{1'b0}};
            r_in_ready <= 1'b0;
            r_state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_acc   <= w_acc_next;
          r_a     <= w_a_next;
          r_b     <= w_b_next;
          r_carry <= w_slice[SLICE];
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == LAST_SLICE) begin
            r_sum       <= w_acc_next;
            r_c_out     <= w_slice[SLICE];
            r_ovf       <= w_msb_cin ^ w_slice[SLICE];
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign c_out     = r_c_out;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_serial_slice_adder.sv
// Scoreboard bench for serial_slice_adder: SLICE=4, SLICE=1 and SLICE=32 instances share operands.
module tb_serial_slice_adder;

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        v;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        c_in = 1'b0;
  logic        op_sub = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;
  logic        iv [3];
  logic        ir [3];
  logic        ov [3];
  logic        co [3];
  logic        vf [3];
  logic [31:0] sm [3];

  int lat [3] = '{8, 32, 1};
  exp_t q [3][$];
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_slice_adder #(.WIDTH(32), .SLICE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .a(a), .b(b), .c_in(c_in),
`ifdef SUBTRACT_EN
    .op_sub(op_sub),
`endif
    .out_valid(ov[0]), .out_ready(out_ready), .sum(sm[0]), .c_out(co[0]), .ovf(vf[0]));

  serial_slice_adder #(.WIDTH(32), .SLICE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .a(a), .b(b), .c_in(c_in),
`ifdef SUBTRACT_EN
    .op_sub(op_sub),
`endif
    .out_valid(ov[1]), .out_ready(out_ready), .sum(sm[1]), .c_out(co[1]), .ovf(vf[1]));

  serial_slice_adder #(.WIDTH(32), .SLICE(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .a(a), .b(b), .c_in(c_in),
`ifdef SUBTRACT_EN
    .op_sub(op_sub),
`endif
    .out_valid(ov[2]), .out_ready(out_ready), .sum(sm[2]), .c_out(co[2]), .ovf(vf[2]));

  // Reference arithmetic: full-width 33-bit add, overflow from operand/result sign bits.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic ci, input logic sub);
    logic [31:0] yy;
    logic [32:0] full;
    exp_t e;
    yy   = sub ? ~y : y;
    full = {1'b0, x} + {1'b0, yy} + {32'h0, (sub ? 1'b1 : ci)};
    e.s  = full[31:0];
    e.c  = full[32];
    e.v  = (x[31] == yy[31]) && (full[31] != x[31]);
    return e;
  endfunction

  task automatic wait_all_idle();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (ir[0] === 1'b1 && ir[1] === 1'b1 && ir[2] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    n_chk++;
    if (!ok) $display("FAIL idle_wait: in_ready got %b%b%b required 111", ir[0], ir[1], ir[2]);
    else n_pass++;
  endtask

  task automatic run_case(input logic [31:0] x, input logic [31:0] y, input logic ci, input logic sub);
    bit   done [3];
    exp_t e;
    int   acc;
    wait_all_idle();
    a = x; b = y; c_in = ci; op_sub = sub;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b1;
      q[k].push_back(model(x, y, ci, sub));
      done[k] = 1'b0;
    end
    @(posedge clk); #1;
    acc = cyc;
    for (int k = 0; k < 3; k++) iv[k] = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (!done[k] && ov[k] === 1'b1) begin
          done[k] = 1'b1;
          e = (q[k].size() > 0) ? q[k].pop_front() : '0;
          n_chk++;
          if (sm[k] !== e.s) $display("FAIL sum dut%0d a=%h b=%h: got %h required %h", k, x, y, sm[k], e.s);
          else n_pass++;
          n_chk++;
          if (co[k] !== e.c) $display("FAIL c_out dut%0d a=%h b=%h: got %b required %b", k, x, y, co[k], e.c);
          else n_pass++;
          n_chk++;
          if (vf[k] !== e.v) $display("FAIL ovf dut%0d a=%h b=%h: got %b required %b", k, x, y, vf[k], e.v);
          else n_pass++;
          n_chk++;
          if (cyc - acc !== lat[k]) $display("FAIL latency dut%0d: got %0d required %0d", k, cyc - acc, lat[k]);
          else n_pass++;
        end
      end
      if (done[0] && done[1] && done[2]) break;
    end
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (!done[k]) $display("FAIL result_timeout dut%0d: got no out_valid required one", k);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (ov[k] !== 1'b0 || ir[k] !== 1'b1 || sm[k] !== 32'h0 || co[k] !== 1'b0 || vf[k] !== 1'b0)
        $display("FAIL reset dut%0d: got ov=%b ir=%b sum=%h c=%b v=%b required 0 1 0 0 0", k, ov[k], ir[k], sm[k], co[k], vf[k]);
      else n_pass++;
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add_cases();
    logic [31:0] ta [7] = '{32'h0000_0005, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0};
    logic [31:0] tb [7] = '{32'h0000_0003, 32'h0000_0000, 32'h0000_0001, 32'h8000_0000, 32'h9ABC_DEF0, 32'h0F0F_0F0F, 32'h0};
    logic        tc [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) run_case(ta[i], tb[i], tc[i], 1'b0);
    for (int i = 0; i < 3; i++) run_case($urandom, $urandom, 1'($urandom_range(1)), 1'b0);
  endtask

  task automatic test_backpressure();
    exp_t e0;
    exp_t e;
    bit   seen;
    bit   done [3];
    wait_all_idle();
    out_ready = 1'b0;
    a = 32'h0F0F_1234; b = 32'h00FF_4321; c_in = 1'b1; op_sub = 1'b0;
    e0 = model(a, b, c_in, 1'b0);
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b1;
      q[k].push_back(e0);
      done[k] = 1'b0;
    end
    @(posedge clk); #1;
    a = 32'hAAAA_AAAA; b = 32'h5555_5555;
    seen = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (ov[0] === 1'b1) begin
        seen = 1'b1;
        break;
      end
      n_chk++;
      if (ir[0] !== 1'b0) $display("FAIL busy_in_ready: got %b required 0", ir[0]);
      else n_pass++;
    end
    for (int t = 0; t < 5; t++) begin
      if (t > 0) @(negedge clk);
      n_chk++;
      if (ov[0] !== 1'b1 || ir[0] !== 1'b0 || sm[0] !== e0.s || co[0] !== e0.c)
        $display("FAIL hold cycle %0d: got ov=%b ir=%b sum=%h c=%b required 1 0 %h %b", t, ov[0], ir[0], sm[0], co[0], e0.s, e0.c);
      else n_pass++;
    end
    for (int k = 0; k < 3; k++) iv[k] = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 40; t++) begin
      if (t > 0) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (!done[k] && ov[k] === 1'b1) begin
          done[k] = 1'b1;
          e = (q[k].size() > 0) ? q[k].pop_front() : '0;
          n_chk++;
          if (sm[k] !== e.s || co[k] !== e.c || vf[k] !== e.v)
            $display("FAIL bp_result dut%0d: got %h/%b/%b required %h/%b/%b", k, sm[k], co[k], vf[k], e.s, e.c, e.v);
          else n_pass++;
        end
      end
      if (done[0] && done[1] && done[2]) break;
    end
    n_chk++;
    if (!(seen && done[0] && done[1] && done[2])) $display("FAIL bp_timeout: got %b%b%b%b required 1111", seen, done[0], done[1], done[2]);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] xa [3] = '{32'h0000_1111, 32'hFFFF_0000, 32'h8000_0001};
    logic [31:0] xb [3] = '{32'h0000_2222, 32'h0001_0000, 32'h8000_0001};
    int   acc_cyc [3];
    int   sent;
    int   got;
    exp_t e;
    wait_all_idle();
    out_ready = 1'b1; op_sub = 1'b0; c_in = 1'b0;
    sent = 0; got = 0;
    for (int t = 0; t < 80; t++) begin
      if (t > 0) @(negedge clk);
      if (ov[0] === 1'b1) begin
        e = (q[0].size() > 0) ? q[0].pop_front() : '0;
        got++;
        n_chk++;
        if (sm[0] !== e.s || co[0] !== e.c || vf[0] !== e.v)
          $display("FAIL b2b_result %0d: got %h/%b/%b required %h/%b/%b", got, sm[0], co[0], vf[0], e.s, e.c, e.v);
        else n_pass++;
      end
      if (sent < 3 && ir[0] === 1'b1) begin
        a = xa[sent]; b = xb[sent];
        iv[0] = 1'b1;
        q[0].push_back(model(xa[sent], xb[sent], 1'b0, 1'b0));
        acc_cyc[sent] = cyc + 1;
        sent++;
      end else begin
        iv[0] = 1'b0;
      end
      if (got == 3) break;
    end
    iv[0] = 1'b0;
    n_chk++;
    if (got != 3) $display("FAIL b2b_count: got %0d required 3", got);
    else n_pass++;
    for (int i = 1; i < 3; i++) begin
      n_chk++;
      if (acc_cyc[i] - acc_cyc[i-1] != 10) $display("FAIL b2b_period %0d: got %0d required 10", i, acc_cyc[i] - acc_cyc[i-1]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_op();
    wait_all_idle();
    a = 32'hFFFF_0000; b = 32'h1234_5678; c_in = 1'b0; op_sub = 1'b0;
    for (int k = 0; k < 3; k++) iv[k] = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) iv[k] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (ov[k] !== 1'b0 || ir[k] !== 1'b1 || sm[k] !== 32'h0)
        $display("FAIL mid_reset dut%0d: got ov=%b ir=%b sum=%h required 0 1 0", k, ov[k], ir[k], sm[k]);
      else n_pass++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_case(32'h1, 32'h1, 1'b0, 1'b0);
  endtask

`ifdef SUBTRACT_EN
  task automatic test_subtract();
    run_case(32'h3, 32'h5, 1'b1, 1'b1);
    run_case(32'h8000_0000, 32'h1, 1'b0, 1'b1);
    run_case(32'h5, 32'h5, 1'b0, 1'b1);
    run_case(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
  endtask
`endif

  initial begin
    for (int k = 0; k < 3; k++) iv[k] = 1'b0;
    test_reset();
    test_add_cases();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_op();
`ifdef SUBTRACT_EN
    test_subtract();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
